// File: rtl/text_term_pkg.sv
// rtl/text_term_pkg.sv - shared types and constants for the text terminal engine
// Package term_pkg: FSM state enum, cursor command enum, screen geometry,
// control codes and the blank character.
package term_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 25;
    localparam int CELLS        = 2000;
    localparam int ROW_BYTES    = 160;
    localparam int SCREEN_BYTES = 2 * CELLS;
    localparam int SCROLL_BYTES = SCREEN_BYTES - ROW_BYTES;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PUT_CHAR,
        PUT_ATTR,
        SCROLL_RD,
        SCROLL_WR,
        BLANK_ROW,
        CLEAR
    } term_state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_INC,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cursor_cmd_e;

endpackage

// File: rtl/text_term_if.sv
// rtl/text_term_if.sv - byte stream, attribute load and text-buffer bus of text_term
// Signals: in_data/in_valid/in_ready byte stream, attr_data/attr_we attribute
// load, mem_address/mem_wdata/mem_we/mem_rdata buffer port, cursor, busy.
// slave = terminal engine side, master = producer/memory side.
interface text_term_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attr_data;
    logic        attr_we;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;
    logic        busy;

    modport slave (
        input  in_data, in_valid, attr_data, attr_we, mem_rdata,
        output in_ready, mem_address, mem_wdata, mem_we, cursor, busy
    );

    modport master (
        output in_data, in_valid, attr_data, attr_we, mem_rdata,
        input  in_ready, mem_address, mem_wdata, mem_we, cursor, busy
    );
endinterface

// File: rtl/text_term_cursor.sv
// rtl/text_term_cursor.sv - row/col tracking and linear cursor register
// Ports: clock, reset (async, active high), i_cmd (cursor command for this
// cycle), o_cursor (row*COLS+col, registered), o_scroll_needed (the current
// command would move the cursor past the bottom row).
module term_cursor
    import term_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  cursor_cmd_e i_cmd,
    output logic [10:0] o_cursor,
    output logic        o_scroll_needed
);

    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [10:0] r_cursor;
    logic [4:0]  w_next_row;
    logic [6:0]  w_next_col;
    logic        w_last_row;
    logic        w_last_col;

    assign w_last_row = (r_row == 5'(ROWS - 1));
    assign w_last_col = (r_col == 7'(COLS - 1));

    // On the bottom row the row index holds; the engine scrolls the buffer instead.
    assign o_scroll_needed = w_last_row &&
                             ((i_cmd == CUR_LF) || ((i_cmd == CUR_INC) && w_last_col));

    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
        case (i_cmd)
            CUR_INC: begin
                if (w_last_col) begin
                    w_next_col = 7'd0;
                    if (!w_last_row) w_next_row = r_row + 5'd1;
                end else begin
                    w_next_col = r_col + 7'd1;
                end
            end
            CUR_CR:  w_next_col = 7'd0;
            CUR_LF: begin
                w_next_col = 7'd0;
                if (!w_last_row) w_next_row = r_row + 5'd1;
            end
            CUR_BS:  if (r_col != 7'd0) w_next_col = r_col - 7'd1;
            CUR_HOME: begin
                w_next_row = 5'd0;
                w_next_col = 7'd0;
            end
            default: ;
        endcase
    end

    // The linear index is recomputed from the next row/col so it changes on
    // the same edge as row/col.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row    <= 5'd0;
            r_col    <= 7'd0;
            r_cursor <= 11'd0;
        end else if (i_cmd != CUR_NONE) begin
            r_row    <= w_next_row;
            r_col    <= w_next_col;
            r_cursor <= ({6'd0, w_next_row} * 11'(COLS)) + {4'd0, w_next_col};
        end
    end

    assign o_cursor = r_cursor;

endmodule

// File: rtl/text_term.sv
// rtl/text_term.sv - character-stream terminal engine for the 80x25 text buffer
// Ports: clock, reset (async, active high), bus (text_term_if.slave): byte
// stream in, attribute load, text-buffer read/write port, cursor index, busy.
// Prints characters with the attribute register, handles CR/LF/BS/FF,
// scrolls one row at the bottom and clears the screen after reset.
module text_term
    import term_pkg::*;
#(
    parameter logic [7:0] RESET_ATTR = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    text_term_if.slave  bus
);

    term_state_e r_state;
    logic [11:0] r_cnt;
    logic [7:0]  r_attr;
    logic        r_mem_we;
    logic [11:0] r_mem_address;
    logic [7:0]  r_mem_wdata;

    cursor_cmd_e w_cmd;
    logic        w_scroll_needed;
    logic [10:0] w_cursor;
    logic        w_accept;
    logic        w_printable;

    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_printable = (bus.in_data >= BLANK);

    always_comb begin
        w_cmd = CUR_NONE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (bus.in_data)
                        CH_CR:   w_cmd = CUR_CR;
                        CH_LF:   w_cmd = CUR_LF;
                        CH_BS:   w_cmd = CUR_BS;
                        default: w_cmd = CUR_NONE;
                    endcase
                end
            end
            PUT_ATTR: w_cmd = CUR_INC;
            CLEAR:    if (r_mem_we && (r_cnt == 12'(SCREEN_BYTES - 1))) w_cmd = CUR_HOME;
            default:  w_cmd = CUR_NONE;
        endcase
    end

    term_cursor u_cursor (
        .clock           (clock),
        .reset           (reset),
        .i_cmd           (w_cmd),
        .o_cursor        (w_cursor),
        .o_scroll_needed (w_scroll_needed)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_attr <= RESET_ATTR;
        else if (bus.attr_we) r_attr <= bus.attr_data;
    end

    // r_cnt is the byte index currently on the memory bus. In CLEAR a low
    // mem_we means the clear has not issued byte 0 yet (the post-reset case).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= CLEAR;
            r_cnt         <= 12'd0;
            r_mem_we      <= 1'b0;
            r_mem_address <= 12'd0;
            r_mem_wdata   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_we <= 1'b0;
                    if (w_accept) begin
                        if (w_printable) begin
                            r_state       <= PUT_CHAR;
                            r_mem_we      <= 1'b1;
                            r_mem_address <= {w_cursor, 1'b0};
                            r_mem_wdata   <= bus.in_data;
                        end else if (bus.in_data == CH_FF) begin
                            r_state       <= CLEAR;
                            r_cnt         <= 12'd0;
                            r_mem_we      <= 1'b1;
                            r_mem_address <= 12'd0;
                            r_mem_wdata   <= BLANK;
                        end else if (w_scroll_needed) begin
                            r_state       <= SCROLL_RD;
                            r_cnt         <= 12'd0;
                            r_mem_address <= 12'(ROW_BYTES);
                        end
                    end
                end
                PUT_CHAR: begin
                    r_state       <= PUT_ATTR;
                    r_mem_address <= {w_cursor, 1'b1};
                    r_mem_wdata   <= r_attr;
                end
                PUT_ATTR: begin
                    r_mem_we <= 1'b0;
                    if (w_scroll_needed) begin
                        r_state       <= SCROLL_RD;
                        r_cnt         <= 12'd0;
                        r_mem_address <= 12'(ROW_BYTES);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCROLL_RD: begin
                    r_state       <= SCROLL_WR;
                    r_mem_we      <= 1'b1;
                    r_mem_address <= r_cnt;
                end
                SCROLL_WR: begin
                    if (r_cnt == 12'(SCROLL_BYTES - 1)) begin
                        r_state       <= BLANK_ROW;
                        r_cnt         <= 12'd0;
                        r_mem_address <= 12'(SCROLL_BYTES);
                        r_mem_wdata   <= BLANK;
                    end else begin
                        r_state       <= SCROLL_RD;
                        r_cnt         <= r_cnt + 12'd1;
                        r_mem_we      <= 1'b0;
                        r_mem_address <= r_cnt + 12'(ROW_BYTES + 1);
                    end
                end
                BLANK_ROW: begin
                    if (r_cnt == 12'(ROW_BYTES - 1)) begin
                        r_state  <= IDLE;
                        r_cnt    <= 12'd0;
                        r_mem_we <= 1'b0;
                    end else begin
                        r_cnt         <= r_cnt + 12'd1;
                        r_mem_address <= r_mem_address + 12'd1;
                        r_mem_wdata   <= r_cnt[0] ? BLANK : r_attr;
                    end
                end
                CLEAR: begin
                    if (!r_mem_we) begin
                        r_cnt         <= 12'd0;
                        r_mem_we      <= 1'b1;
                        r_mem_address <= 12'd0;
                        r_mem_wdata   <= BLANK;
                    end else if (r_cnt == 12'(SCREEN_BYTES - 1)) begin
                        r_state  <= IDLE;
                        r_cnt    <= 12'd0;
                        r_mem_we <= 1'b0;
                    end else begin
                        r_cnt         <= r_cnt + 12'd1;
                        r_mem_address <= r_cnt + 12'd1;
                        r_mem_wdata   <= r_cnt[0] ? BLANK : r_attr;
                    end
                end
                default: begin
                    r_state  <= CLEAR;
                    r_cnt    <= 12'd0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    // Busy covers every bulk buffer operation, including the row blanking
    // that finishes a scroll.
    assign bus.busy        = (r_state == SCROLL_RD) || (r_state == SCROLL_WR) ||
                             (r_state == BLANK_ROW) || (r_state == CLEAR);
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_address = r_mem_address;
    // Read data arrives in the SCROLL_WR cycle itself, so it bypasses the register.
    assign bus.mem_wdata   = (r_state == SCROLL_WR) ? bus.mem_rdata : r_mem_wdata;
    assign bus.cursor      = w_cursor;

endmodule

// File: tb/tb_text_term.sv
// tb/tb_text_term.sv - scoreboard bench for text_term
module tb_text_term;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #20 clock = ~clock;

    text_term_if bus ();

    text_term dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:4095];
    logic [7:0] rdata_r;
    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
        rdata_r <= mem[bus.mem_address];
    end
    assign bus.mem_rdata = rdata_r;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] refm [0:3999];
    int         mrow = 0;
    int         mcol = 0;
    logic [7:0] mattr = 8'h07;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        wr_t e;
        if (!reset && bus.mem_we) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%02h with no write expected",
                         bus.mem_address, bus.mem_wdata);
            end else begin
                e = q.pop_front();
                if (bus.mem_address !== e.a || bus.mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                             bus.mem_address, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic push(input int a, input logic [7:0] d);
        q.push_back('{a: 12'(a), d: d});
        refm[a] = d;
    endtask

    task automatic push_scroll();
        for (int i = 0; i < 3840; i++) push(i, refm[i + 160]);
        for (int j = 0; j < 160; j++) push(3840 + j, (j % 2 == 1) ? mattr : 8'h20);
    endtask

    task automatic push_clear();
        for (int k = 0; k < 4000; k++) push(k, (k % 2 == 1) ? mattr : 8'h20);
    endtask

    task automatic model(input logic [7:0] b);
        int cur;
        cur = mrow * 80 + mcol;
        if (b >= 8'h20) begin
            push(2 * cur, b);
            push(2 * cur + 1, mattr);
            if (mcol == 79) begin
                mcol = 0;
                if (mrow == 24) push_scroll();
                else mrow++;
            end else begin
                mcol++;
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mcol = 0;
            if (mrow == 24) push_scroll();
            else mrow++;
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            push_clear();
            mrow = 0;
            mcol = 0;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.in_ready && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: in_ready=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready("ready_timeout");
        model(b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic set_attr(input logic [7:0] a);
        @(negedge clock);
        bus.attr_data = a;
        bus.attr_we   = 1'b1;
        @(posedge clock);
        #1 bus.attr_we = 1'b0;
        mattr = a;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int n;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.attr_data = 8'h00;
        bus.attr_we   = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_cursor", int'(bus.cursor), 0);
        check("rst_mem_address", int'(bus.mem_address), 0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
        push_clear();
        reset = 1'b0;
        wait_ready("init_clear");
        check("init_clear_drained", q.size(), 0);
        check("init_cursor", int'(bus.cursor), 0);

        // 'A' with attribute 1E: cycle-level timing
        set_attr(8'h1E);
        send(8'h41);
        @(negedge clock);
        check("A_t1_we", int'(bus.mem_we), 1);
        check("A_t1_addr", int'(bus.mem_address), 0);
        check("A_t1_ready", int'(bus.in_ready), 0);
        check("A_t1_cursor", int'(bus.cursor), 0);
        @(negedge clock);
        check("A_t2_addr", int'(bus.mem_address), 1);
        check("A_t2_cursor", int'(bus.cursor), 0);
        @(negedge clock);
        check("A_t3_cursor", int'(bus.cursor), 1);
        check("A_t3_ready", int'(bus.in_ready), 1);

        // CR updates the cursor on the next cycle with no stall
        send(8'h0D);
        @(negedge clock);
        check("cr_cursor", int'(bus.cursor), 0);
        check("cr_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 80; i++) send(8'(8'h30 + i));
        send(8'h0D);
        send(8'h0A);
        @(negedge clock);
        check("row2_cursor", int'(bus.cursor), 160);
        send(8'h08);
        @(negedge clock);
        check("bs_col0_cursor", int'(bus.cursor), 160);
        send(8'h78);
        send(8'h08);
        @(negedge clock);
        check("bs_col1_cursor", int'(bus.cursor), 160);

        // Fill to the last cell, then wrap into a scroll
        for (int i = 0; i < 22; i++) send(8'h0A);
        @(negedge clock);
        check("last_row_cursor", int'(bus.cursor), 1920);
        for (int i = 0; i < 79; i++) send(8'(8'h41 + (i % 26)));
        wait_ready("fill_row");
        check("last_cell_cursor", int'(bus.cursor), 1999);
        send(8'h5A);
        n = 0;
        @(negedge clock);
        while (!bus.busy && n < 10) begin
            @(negedge clock);
            n++;
        end
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 20000) begin
            busy_cycles++;
            @(negedge clock);
        end
        check("scroll_busy_cycles", busy_cycles, 7840);
        check("scroll_cursor", int'(bus.cursor), 1920);
        check("scroll_drained", q.size(), 0);

        // Form feed with a new attribute
        send(8'h42);
        set_attr(8'h2A);
        send(8'h0C);
        wait_ready("ff_clear");
        check("ff_cursor", int'(bus.cursor), 0);
        check("ff_drained", q.size(), 0);

        // Attribute load during PUT_ATTR: old value is written
        set_attr(8'h07);
        send(8'h43);
        @(negedge clock);
        @(negedge clock);
        bus.attr_data = 8'h4F;
        bus.attr_we   = 1'b1;
        @(posedge clock);
        #1 bus.attr_we = 1'b0;
        mattr = 8'h4F;
        send(8'h44);
        wait_ready("attr_pulse");
        check("attr_cursor", int'(bus.cursor), 2);
        check("attr_drained", q.size(), 0);

        // Reset in the middle of an LF-triggered scroll
        for (int i = 0; i < 24; i++) send(8'h0A);
        @(negedge clock);
        check("lf_bottom_cursor", int'(bus.cursor), 1920);
        send(8'h0A);
        repeat (1000) @(posedge clock);
        #5 reset = 1'b1;
        q.delete();
        mattr = 8'h07;
        mrow  = 0;
        mcol  = 0;
        push_clear();
        @(negedge clock);
        check("midrst_busy", int'(bus.busy), 1);
        check("midrst_ready", int'(bus.in_ready), 0);
        check("midrst_mem_we", int'(bus.mem_we), 0);
        check("midrst_cursor", int'(bus.cursor), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_ready("midrst_clear");
        check("midrst_final_cursor", int'(bus.cursor), 0);
        check("midrst_drained", q.size(), 0);

        repeat (4) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
